// File: rtl/demux1x16_tdm.sv
// Time-division 1:N demultiplexer: collects a framed serial stream into a shadow
// register and presents each completed frame on out with a one-cycle out_valid strobe.
module demux1x16_tdm #(
    parameter int N_OUT = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             start,
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic [SEL_W-1:0] slot,
    output logic             err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_OUT - 1);

    logic [0:0]       state;
    logic [N_OUT-1:0] shadow;
    logic [N_OUT-1:0] frame_done;
    logic [N_OUT-1:0] frame_first;

    // Completed frame takes the final bit straight from the input, not via shadow.
    always_comb begin
        frame_done            = shadow;
        frame_done[N_OUT-1]   = in;
        frame_first           = '0;
        frame_first[0]        = in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            out       <= '0;
            slot      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            shadow <= frame_first;
                            slot   <= SEL_W'(1);
                            state  <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (start) begin
                            // Abort restarts collection with this bit as slot 0.
                            err    <= 1'b1;
                            shadow <= frame_first;
                            slot   <= SEL_W'(1);
                        end else if (slot == LAST_SLOT) begin
                            out       <= frame_done;
                            out_valid <= 1'b1;
                            shadow    <= frame_done;
                            slot      <= '0;
                            state     <= IDLE;
                        end else begin
                            shadow[slot] <= in;
                            slot         <= slot + SEL_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        slot  <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_demux1x16_tdm.sv
// Directed table-driven bench for demux1x16_tdm plus a hand-written
// start-on-final-slot abort sequence.
module tb_demux1x16_tdm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in = 1'b0;
    logic        in_valid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;
    logic [3:0]  slot;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic        st;
        logic        din;
        logic [15:0] eo;
        logic        ev;
        logic        eb;
        logic [3:0]  es;
        logic        ee;
    } vec_t;

    vec_t        vq[$];
    logic [15:0] held;

    demux1x16_tdm #(.N_OUT(16), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .start(start),
        .out(out), .out_valid(out_valid), .busy(busy), .slot(slot), .err(err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic iv, input logic st, input logic d,
                       input logic [15:0] eo, input logic ev, input logic eb,
                       input logic [3:0] es, input logic ee);
        vec_t v;
        v.rst = r; v.iv = iv; v.st = st; v.din = d;
        v.eo = eo; v.ev = ev; v.eb = eb; v.es = es; v.ee = ee;
        vq.push_back(v);
    endtask

    // Bits lo..hi of frame d, LSB first, start on bit 0.
    task automatic send_bits(input logic [15:0] d, input int lo, input int hi, input bit abort);
        for (int i = lo; i <= hi; i++) begin
            if (i == 15) held = d;
            add(1'b0, 1'b1, (i == 0), d[i], held, (i == 15), (i != 15),
                (i == 15) ? 4'd0 : 4'(i + 1), abort && (i == 0));
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic st, input logic d);
        @(negedge clk);
        rst = r; in_valid = iv; start = st; in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out/valid/busy/slot/err=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        held = 16'h0000;
        // 1: reset with in_valid/start asserted
        add(1, 1, 1, 1, 16'h0000, 0, 0, 4'd0, 0);
        add(1, 1, 1, 1, 16'h0000, 0, 0, 4'd0, 0);
        // 2: plain frame, then idle cycle shows one-cycle strobe
        send_bits(16'hA5C3, 0, 15, 0);
        add(0, 0, 0, 0, held, 0, 0, 4'd0, 0);
        // 3: same frame with a 3-cycle in_valid gap after bit 7
        send_bits(16'hA5C3, 0, 7, 0);
        add(0, 0, 1, 1, held, 0, 1, 4'd8, 0);
        add(0, 0, 0, 0, held, 0, 1, 4'd8, 0);
        add(0, 0, 1, 0, held, 0, 1, 4'd8, 0);
        send_bits(16'hA5C3, 8, 15, 0);
        // 4: abort at slot 9, then full 0x1234
        send_bits(16'hFFFF, 0, 8, 0);
        send_bits(16'h1234, 0, 15, 1);
        add(0, 0, 0, 0, held, 0, 0, 4'd0, 0);
        // 5: stray valid bits while IDLE, then reset at slot 6
        for (int i = 0; i < 5; i++) add(0, 1, 0, i[0], held, 0, 0, 4'd0, 0);
        send_bits(16'h0F0F, 0, 5, 0);
        held = 16'h0000;
        add(1, 1, 1, 1, held, 0, 0, 4'd0, 0);
        add(0, 0, 0, 0, held, 0, 0, 4'd0, 0);
        // 6: loopback of mux16x1 with in=0xBEEF, two frames back-to-back
        send_bits(16'hBEEF, 0, 15, 0);
        send_bits(16'hBEEF, 0, 15, 0);
        add(0, 0, 0, 0, held, 0, 0, 4'd0, 0);

        for (int k = 0; k < vq.size(); k++) begin
            step(vq[k].rst, vq[k].iv, vq[k].st, vq[k].din);
            check($sformatf("vec%0d", k), {out, out_valid, busy, slot, err},
                  {vq[k].eo, vq[k].ev, vq[k].eb, vq[k].es, vq[k].ee});
        end

        // Start on the final slot bit is an abort, not a completion.
        for (int i = 0; i < 15; i++) step(0, 1, (i == 0), 1'b1);
        check("pre_final_slot", {out, out_valid, busy, slot, err},
              {16'hBEEF, 1'b0, 1'b1, 4'd15, 1'b0});
        step(0, 1, 1, 1'b1);
        check("final_slot_abort", {out, out_valid, busy, slot, err},
              {16'hBEEF, 1'b0, 1'b1, 4'd1, 1'b1});
        for (int i = 1; i < 15; i++) step(0, 1, 0, 1'b0);
        step(0, 1, 0, 1'b1);
        check("after_abort_frame", {out, out_valid, busy, slot, err},
              {16'h8001, 1'b1, 1'b0, 4'd0, 1'b0});
        step(0, 0, 0, 1'b0);
        check("after_abort_hold", {out, out_valid, busy, slot, err},
              {16'h8001, 1'b0, 1'b0, 4'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
